hash_arbiter: RTL and testbench
===============================

HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of trace requesters (2..8).
REQ-002 SHALL have parameter HASH_W, default 13, width of hash result.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous active-low reset (asserted at 0).
REQ-005 SHALL have port req_valid  in  NUM_SRC  per-source trace valid.
REQ-006 SHALL have port req_trace  in  NUM_SRC x 32  per-source trace word.
REQ-007 SHALL have port req_ready  out  NUM_SRC  per-source accept, one-hot or zero.
REQ-008 SHALL have port out_valid  out  1  hash result valid.
REQ-009 SHALL have port out_ready  in  1  downstream accepts result.
REQ-010 SHALL have port out_hash  out  HASH_W  hash of accepted trace.
REQ-011 SHALL have port out_src  out  clog2(NUM_SRC)  source index of out_hash.
REQ-012 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL share one mixing-hash core (seed 32'hdeadbef3, seven xor/subtract/rotate rounds, low HASH_W bits of c) among all sources.
REQ-014 SHALL implement FSM states IDLE, HASH, HOLD.
REQ-015 IDLE: if any req_valid, SHALL assert req_ready for the granted source in the same cycle, latch trace and index, and go to HASH; otherwise stay in IDLE.
REQ-016 HASH: SHALL register the core result into out_hash/out_src, set out_valid, and go to HOLD; lasts exactly one cycle.
REQ-017 HOLD: SHALL hold out_valid, out_hash and out_src stable until out_ready=1.
REQ-018 HOLD with out_ready=1 and any req_valid: SHALL accept the next grant in the same cycle and go to HASH (back-to-back, one result per 2 cycles).
REQ-019 HOLD with out_ready=1 and no req_valid: SHALL clear out_valid and go to IDLE.
REQ-020 Latency: acceptance in cycle N SHALL give out_valid=1 in cycle N+2.
REQ-021 Grant: round-robin; SHALL search from last_grant+1 upward, wrapping at NUM_SRC-1 to 0; last_grant updates only on acceptance.
REQ-022 req_ready SHALL be 0 for all sources in HASH, and in HOLD while out_ready=0.
REQ-023 A source that drops req_valid before acceptance SHALL NOT be granted; no request is lost or duplicated.
REQ-024 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-025 On reset=0: FSM=IDLE, out_valid=0, out_hash=0, out_src=0, req_ready=0, busy=0, last_grant=NUM_SRC-1 (so source 0 has first priority).
REQ-026 Reset mid-operation SHALL discard any in-flight hash with no output pulse; operation resumes on the first edge after release.

Configuration
REQ-027 Macro HASH_ARB_STATS_EN, when defined, SHALL add outputs grant_cnt (NUM_SRC x 16), a per-source count of accepted requests that saturates at 16'hFFFF and is cleared by reset.
REQ-028 Without HASH_ARB_STATS_EN, the grant_cnt ports and counters SHALL be absent, with identical remaining behaviour.

Structure
REQ-029 Package hash_pkg SHALL hold the seed constant, the rotation amounts, HASH_W default, and the FSM state enum.
REQ-030 The mixing rounds SHALL live in sub-module hash_core (combinational, 32-bit in, HASH_W out), instantiated once.

Verification
REQ-031 Single request: src 2 trace 32'h0000_1000, out_ready=1 -> req_ready[2] in cycle N, out_valid in N+2, out_src=2, out_hash equals the golden model.
REQ-032 All four sources valid continuously, out_ready=1 -> grants in order 0,1,2,3,0,1; one result every 2 cycles.
REQ-033 out_ready=0 for 5 cycles in HOLD -> out_hash/out_src stable, req_ready all 0; on release, the next source is granted the same cycle.
REQ-034 Reset=0 asserted in HASH -> out_valid stays 0; after release, source 0 is granted first.
REQ-035 With HASH_ARB_STATS_EN: 70000 grants to src 1 -> grant_cnt[1]=16'hFFFF, other counts correct.
REQ-036 Src 3 drops req_valid one cycle before its turn -> src 3 is skipped and the grant passes to the next valid source.

Source files
------------

// File: rtl/hash_pkg.sv
// Shared constants, FSM state type and rotate helper for the hash arbiter.
package hash_pkg;

    localparam int unsigned HASH_W_DEF = 13;
    localparam logic [31:0] HASH_SEED  = 32'hdeadbef3;

    // Rotate amounts for the seven mixing rounds, applied in order.
    localparam int unsigned ROT [7] = '{14, 11, 25, 16, 4, 14, 24};

    typedef enum logic [1:0] {
        StIdle,
        StHash,
        StHold
    } state_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/hash_core.sv
// Combinational seven-round xor/subtract/rotate mix of one 32-bit word.
module hash_core
    import hash_pkg::*;
#(
    parameter int unsigned HASH_W = HASH_W_DEF
) (
    input  logic [31:0]       key_i,
    output logic [HASH_W-1:0] hash_o
);

    logic [31:0] a, b, c;

    always_comb begin
        a = HASH_SEED + key_i;
        b = HASH_SEED;
        c = HASH_SEED;
        c = (c ^ b) - rotl(b, ROT[0]);
        a = (a ^ c) - rotl(c, ROT[1]);
        b = (b ^ a) - rotl(a, ROT[2]);
        c = (c ^ b) - rotl(b, ROT[3]);
        a = (a ^ c) - rotl(c, ROT[4]);
        b = (b ^ a) - rotl(a, ROT[5]);
        c = (c ^ b) - rotl(b, ROT[6]);
    end

    assign hash_o = HASH_W'(c);

endmodule

// File: rtl/hash_arbiter.sv
// Round-robin arbiter feeding one shared hash core, one result per two cycles.
// Define HASH_ARB_STATS_EN to add saturating per-source grant counters (grant_cnt).
module hash_arbiter
    import hash_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned HASH_W  = HASH_W_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_SRC-1:0]               req_valid,
    input  logic [NUM_SRC-1:0][31:0]         req_trace,
    output logic [NUM_SRC-1:0]               req_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [HASH_W-1:0]                out_hash,
    output logic [$clog2(NUM_SRC)-1:0]       out_src,
`ifdef HASH_ARB_STATS_EN
    output logic [NUM_SRC-1:0][15:0]         grant_cnt,
`endif
    output logic                             busy
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);

    state_e             state_q;
    logic [SRC_W-1:0]   last_grant_q;
    logic [SRC_W-1:0]   src_q;
    logic [31:0]        trace_q;
    logic               out_valid_q;
    logic [HASH_W-1:0]  out_hash_q;
    logic [SRC_W-1:0]   out_src_q;
    logic [HASH_W-1:0]  core_hash;

    logic               any_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand;
    logic               can_accept;
    logic               accept;

    // Search starts one past the last grant and wraps, so the first hit is round-robin fair.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = last_grant_q;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = SRC_W'((32'(last_grant_q) + i) % NUM_SRC);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign can_accept = (state_q == StIdle) || ((state_q == StHold) && out_ready);
    // Gate with reset so no source sees a grant while the block is held in reset.
    assign accept     = reset && can_accept && any_valid;

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            req_ready[i] = accept && (grant_idx == SRC_W'(i));
        end
    end

    hash_core #(
        .HASH_W (HASH_W)
    ) u_hash_core (
        .key_i  (trace_q),
        .hash_o (core_hash)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
            src_q        <= '0;
            trace_q      <= '0;
            out_valid_q  <= 1'b0;
            out_hash_q   <= '0;
            out_src_q    <= '0;
        end else begin
            if (accept) begin
                trace_q      <= req_trace[grant_idx];
                src_q        <= grant_idx;
                last_grant_q <= grant_idx;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) state_q <= StHash;
                end
                StHash: begin
                    out_hash_q  <= core_hash;
                    out_src_q   <= src_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= accept ? StHash : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_hash  = out_hash_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q != StIdle);

`ifdef HASH_ARB_STATS_EN
    logic [NUM_SRC-1:0][15:0] grant_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (accept && (grant_idx == SRC_W'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter; stats checks compile in with HASH_ARB_STATS_EN.
module tb_hash_arbiter;

    logic              clk;
    logic              reset;
    logic [3:0]        req_valid;
    logic [3:0][31:0]  req_trace;
    logic [3:0]        req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [12:0]       out_hash;
    logic [1:0]        out_src;
    logic              busy;
`ifdef HASH_ARB_STATS_EN
    logic [3:0][15:0]  grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hash_arbiter #(
        .NUM_SRC (4),
        .HASH_W  (13)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_trace (req_trace),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
        .out_src   (out_src),
`ifdef HASH_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    // Reference mix: a = seed + key, b = c = seed, then the seven final rounds.
    function automatic logic [12:0] golden(input logic [31:0] k);
        logic [31:0] a, b, c;
        a = 32'hdeadbef3 + k;
        b = 32'hdeadbef3;
        c = 32'hdeadbef3;
        c = c ^ b; c = c - rol(b, 14);
        a = a ^ c; a = a - rol(c, 11);
        b = b ^ a; b = b - rol(a, 25);
        c = c ^ b; c = c - rol(b, 16);
        a = a ^ c; a = a - rol(c, 4);
        b = b ^ a; b = b - rol(a, 14);
        c = c ^ b; c = c - rol(b, 24);
        return c[12:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'hF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_hash !== 13'h0) begin errors++; $display("FAIL reset_out_hash: got %h want 0", out_hash); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src: got %0d want 0", out_src); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        req_valid = 4'h0;
        reset     = 1'b1;
        next_cycle();
    endtask

    task automatic test_single();
        req_trace[2] = 32'h0000_1000;
        req_valid    = 4'b0100;
        out_ready    = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        next_cycle();
        req_valid = 4'b0000;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_n1_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_n1_busy: got %b want 1", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_n1_ready: got %b want 0000", req_ready); end
        next_cycle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_n2_valid: got %b want 1", out_valid); end
        checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL single_src: got %0d want 2", out_src); end
        checks++; if (out_hash !== golden(32'h0000_1000)) begin errors++; $display("FAIL single_hash: got %h want %h", out_hash, golden(32'h0000_1000)); end
        next_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        int         s;
        pulse_reset();
        req_trace[0] = 32'hA5A5_0000;
        req_trace[1] = 32'h1234_5678;
        req_trace[2] = 32'hFFFF_FFFF;
        req_trace[3] = 32'h0000_0001;
        req_valid    = 4'hF;
        out_ready    = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_grant: got %b want 0001", req_ready); end
        for (int k = 0; k < 6; k++) begin
            s = k % 4;
            next_cycle();
            checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL rr_hash_cycle %0d: ready %b valid %b want 0000 0", k, req_ready, out_valid); end
            next_cycle();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'(s)) begin errors++; $display("FAIL rr_result %0d: valid %b src %0d want 1 %0d", k, out_valid, out_src, s); end
            checks++; if (out_hash !== golden(req_trace[s])) begin errors++; $display("FAIL rr_hash %0d: got %h want %h", k, out_hash, golden(req_trace[s])); end
            if (k < 5) begin
                exp_ready = 4'b0001 << ((k + 1) % 4);
                checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant %0d: got %b want %b", k, req_ready, exp_ready); end
            end else begin
                req_valid = 4'h0;
                #1;
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_no_grant: got %b want 0000", req_ready); end
            end
        end
        next_cycle();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_idle: valid %b busy %b want 0 0", out_valid, busy); end
    endtask

    task automatic test_hold_stall();
        req_valid = 4'b1100;
        out_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_grant: got %b want 0100", req_ready); end
        next_cycle();
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin errors++; $display("FAIL stall_hold %0d: valid %b src %0d want 1 2", k, out_valid, out_src); end
            checks++; if (out_hash !== golden(req_trace[2])) begin errors++; $display("FAIL stall_hash %0d: got %h want %h", k, out_hash, golden(req_trace[2])); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready %0d: got %b want 0000", k, req_ready); end
            next_cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_release: ready %b valid %b want 1000 1", req_ready, out_valid); end
        next_cycle();
        req_valid = 4'b0000;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_hash_valid: got %b want 0", out_valid); end
        next_cycle();
        checks++; if (out_src !== 2'd3 || out_hash !== golden(req_trace[3])) begin errors++; $display("FAIL stall_next: src %0d hash %h want 3 %h", out_src, out_hash, golden(req_trace[3])); end
        next_cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_grant: got %b want 0010", req_ready); end
        next_cycle();
        req_valid = 4'b0000;
        reset     = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_in_reset: valid %b busy %b want 0 0", out_valid, busy); end
        next_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_pulse: got %b want 0", out_valid); end
        reset     = 1'b1;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first_src0: got %b want 0001", req_ready); end
        next_cycle();
        next_cycle();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL rmid_result: valid %b src %0d want 1 0", out_valid, out_src); end
        checks++; if (out_hash !== golden(req_trace[0])) begin errors++; $display("FAIL rmid_hash: got %h want %h", out_hash, golden(req_trace[0])); end
        req_valid = 4'b0000;
        next_cycle();
    endtask

    task automatic test_drop();
        req_valid = 4'b1011;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL drop_first: got %b want 0010", req_ready); end
        next_cycle();
        req_valid = 4'b0001;
        next_cycle();
        checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL drop_src1: got %0d want 1", out_src); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL drop_skip3: got %b want 0001", req_ready); end
        next_cycle();
        req_valid = 4'b0000;
        next_cycle();
        checks++; if (out_src !== 2'd0 || out_hash !== golden(req_trace[0])) begin errors++; $display("FAIL drop_result: src %0d hash %h want 0 %h", out_src, out_hash, golden(req_trace[0])); end
        next_cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b want 0", busy); end
    endtask

`ifdef HASH_ARB_STATS_EN
    task automatic test_stats();
        pulse_reset();
        #1;
        checks++; if (grant_cnt !== 64'h0) begin errors++; $display("FAIL stats_reset: got %h want 0", grant_cnt); end
        req_valid = 4'b0010;
        out_ready = 1'b1;
        repeat (20) next_cycle();
        checks++; if (grant_cnt[1] !== 16'd10) begin errors++; $display("FAIL stats_ten: got %0d want 10", grant_cnt[1]); end
        repeat (139980) next_cycle();
        req_valid = 4'b0000;
        repeat (3) next_cycle();
        checks++; if (grant_cnt[1] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h want ffff", grant_cnt[1]); end
        checks++; if (grant_cnt[0] !== 16'h0 || grant_cnt[2] !== 16'h0 || grant_cnt[3] !== 16'h0) begin errors++; $display("FAIL stats_others: got %h want 0", grant_cnt); end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        req_valid = 4'h0;
        req_trace = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_stall();
        test_reset_mid();
        test_drop();
`ifdef HASH_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
